// File: rtl/vreduce_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vreduce_acc                                                     |
// | Function : Horizontal sum of all lanes of a packed SIMD vector,            |
// |            LANES_PER_CYCLE lanes per clock. Optional macro                 |
// |            VREDUCE_SAT_EN clamps the result to the LANE_W range.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vreduce_acc #(
    parameter int LANES           = 16,
    parameter int LANE_W          = 16,
    parameter int LANES_PER_CYCLE = 4,
    parameter int ACC_W           = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [LANES*LANE_W-1:0] Vector,
    input  logic                    Signed,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [ACC_W-1:0]        Result,
    output logic                    Sat
);

    localparam int c_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LANES - LANES_PER_CYCLE);
    localparam logic [c_IDX_W-1:0] c_IDX_STEP = c_IDX_W'(LANES_PER_CYCLE);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [LANES*LANE_W-1:0] r_vec;
    logic                    r_signed;
    logic [c_IDX_W-1:0]      r_idx;
    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        r_result;
    logic                    r_sat;
    logic                    r_in_ready;
    logic [LANE_W-1:0]       w_lane;
    logic [ACC_W-1:0]        w_group_sum;
    logic [ACC_W-1:0]        w_acc_next;
    logic [ACC_W-1:0]        w_result;
    logic                    w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (InValid && r_in_ready) w_state_next = c_ST_ACCUM;
            c_ST_ACCUM: if (r_idx == c_LAST_IDX) w_state_next = c_ST_DONE;
            c_ST_DONE:  if (OutReady) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Sum of the current lane group, each lane extended per the captured Signed.
    always_comb begin
        w_group_sum = '0;
        w_lane      = '0;
        for (int k = 0; k < LANES_PER_CYCLE; k++) begin
            w_lane      = r_vec[(int'(r_idx) + k)*LANE_W +: LANE_W];
            w_group_sum = w_group_sum +
                          {{(ACC_W-LANE_W){r_signed & w_lane[LANE_W-1]}}, w_lane};
        end
    end

    assign w_acc_next = r_acc + w_group_sum;

`ifdef VREDUCE_SAT_EN
    localparam logic [ACC_W-1:0] c_SMAX = ACC_W'((1 << (LANE_W-1)) - 1);
    localparam logic [ACC_W-1:0] c_SMIN = ACC_W'(-(1 << (LANE_W-1)));
    localparam logic [ACC_W-1:0] c_UMAX = ACC_W'((1 << LANE_W) - 1);

    always_comb begin
        w_result = w_acc_next;
        w_sat    = 1'b0;
        if (r_signed) begin
            if ($signed(w_acc_next) > $signed(c_SMAX)) begin
                w_result = c_SMAX;
                w_sat    = 1'b1;
            end else if ($signed(w_acc_next) < $signed(c_SMIN)) begin
                w_result = c_SMIN;
                w_sat    = 1'b1;
            end
        end else if (w_acc_next > c_UMAX) begin
            w_result = c_UMAX;
            w_sat    = 1'b1;
        end
    end
`else
    assign w_result = w_acc_next;
    assign w_sat    = 1'b0;
`endif

    // Result/Sat load only on the final ACCUM cycle so they stay frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= '0;
            r_signed   <= 1'b0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_sat      <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (InValid && r_in_ready) begin
                        r_vec    <= Vector;
                        r_signed <= Signed;
                        r_acc    <= '0;
                        r_idx    <= '0;
                    end
                end
                c_ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + c_IDX_STEP;
                    if (r_idx == c_LAST_IDX) begin
                        r_result <= w_result;
                        r_sat    <= w_sat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign InReady  = r_in_ready;
    assign OutValid = (r_state == c_ST_DONE);
    assign Result   = r_result;
    assign Sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_vreduce_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vreduce_acc                                                  |
// | Function : Self-checking bench for vreduce_acc (table + scoreboard).       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vreduce_acc;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int ACC_W  = 20;
    localparam int VW     = LANES*LANE_W;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             InValid  = 1'b0;
    logic             Signed   = 1'b0;
    logic             OutReady = 1'b0;
    logic [VW-1:0]    Vector   = '0;
    logic             InReady;
    logic             OutValid;
    logic [ACC_W-1:0] Result;
    logic             Sat;

    vreduce_acc #(.LANES(LANES), .LANE_W(LANE_W), .LANES_PER_CYCLE(4), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .Vector(Vector), .Signed(Signed), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Sat(Sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0]    vec;
        logic             sgn;
        logic [ACC_W-1:0] res;
        logic             sat;
    } vec_t;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             sat;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t tbl[7];

    function automatic logic [VW-1:0] fill(input logic [LANE_W-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < VW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic exp_t model(input logic [VW-1:0] vec, input logic sgn);
        exp_t              e;
        longint            s;
        logic [LANE_W-1:0] lane;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            lane = vec[i*LANE_W +: LANE_W];
            s += sgn ? longint'($signed(lane)) : longint'(lane);
        end
        e.res = ACC_W'(s);
        e.sat = 1'b0;
`ifdef VREDUCE_SAT_EN
        if (sgn && s > 32767)           begin e.res = 20'h07FFF; e.sat = 1'b1; end
        else if (sgn && s < -32768)     begin e.res = 20'hF8000; e.sat = 1'b1; end
        else if (!sgn && s > 65535)     begin e.res = 20'h0FFFF; e.sat = 1'b1; end
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [VW-1:0] vec, input logic sgn,
                        input exp_t e, input bit push);
        @(negedge clk);
        check("in_ready_before_send", 32'(InReady), 32'd1);
        InValid = 1'b1;
        Vector  = vec;
        Signed  = sgn;
        if (push) sb.push_back(e);
        @(negedge clk);
        InValid = 1'b0;
        Vector  = rand_vec();
        Signed  = 1'($urandom);
    endtask

    // Called on the first negedge after the input handshake.
    task automatic collect();
        int   cnt;
        exp_t e;
        cnt = 1;
        while (!OutValid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", 32'(cnt), 32'd5);
        if (OutValid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got OutValid with no pending result");
            end else begin
                e = sb.pop_front();
                check("result", 32'(Result), 32'(e.res));
                check("sat", 32'(Sat), 32'(e.sat));
            end
            if (OutReady) begin
                @(negedge clk);
                check("out_valid_pulse", 32'(OutValid), 32'd0);
                check("in_ready_after_out", 32'(InReady), 32'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] ramp;
        exp_t          e;
        int            extra;

        tbl[0] = '{fill(16'h0001), 1'b0, 20'h00010, 1'b0};
`ifdef VREDUCE_SAT_EN
        tbl[1] = '{fill(16'h8000), 1'b1, 20'hF8000, 1'b1};
        tbl[2] = '{fill(16'hFFFF), 1'b0, 20'h0FFFF, 1'b1};
        tbl[3] = '{fill(16'h8000), 1'b0, 20'h0FFFF, 1'b1};
`else
        tbl[1] = '{fill(16'h8000), 1'b1, 20'h80000, 1'b0};
        tbl[2] = '{fill(16'hFFFF), 1'b0, 20'hFFFF0, 1'b0};
        tbl[3] = '{fill(16'h8000), 1'b0, 20'h80000, 1'b0};
`endif
        tbl[4] = '{fill(16'hFFFF), 1'b1, 20'hFFFF0, 1'b0};
        tbl[5].vec = rand_vec(); tbl[5].sgn = 1'b0;
        e = model(tbl[5].vec, 1'b0); tbl[5].res = e.res; tbl[5].sat = e.sat;
        tbl[6].vec = rand_vec(); tbl[6].sgn = 1'b1;
        e = model(tbl[6].vec, 1'b1); tbl[6].res = e.res; tbl[6].sat = e.sat;

        // Reset with busy inputs
        InValid = 1'b1; Vector = rand_vec(); Signed = 1'b1; OutReady = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(InReady),  32'd0);
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_result",    32'(Result),   32'd0);
        check("rst_sat",       32'(Sat),      32'd0);
        InValid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(InReady), 32'd1);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].vec, tbl[i].sgn, '{tbl[i].res, tbl[i].sat}, 1'b1);
            collect();
        end

        // Backpressure, with a competing InValid that must be ignored
        for (int i = 0; i < LANES; i++) ramp[i*LANE_W +: LANE_W] = 16'(i);
        OutReady = 1'b0;
        send(ramp, 1'b0, '{20'd120, 1'b0}, 1'b1);
        collect();
        InValid = 1'b1;
        Vector  = fill(16'h7777);
        Signed  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(OutValid), 32'd1);
            check("bp_result",    32'(Result),   32'd120);
            check("bp_sat",       32'(Sat),      32'd0);
            check("bp_in_ready",  32'(InReady),  32'd0);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(OutValid), 32'd0);
        check("bp_release_ready", 32'(InReady),  32'd1);
        send(tbl[5].vec, tbl[5].sgn, '{tbl[5].res, tbl[5].sat}, 1'b1);
        collect();

        // Reset during the second ACCUM cycle
        send(fill(16'h0003), 1'b0, '{20'd0, 1'b0}, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(OutValid), 32'd0);
        check("midrst_in_ready",  32'(InReady),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_release", 32'(InReady), 32'd1);
        send(fill(16'h0002), 1'b0, '{20'h00020, 1'b0}, 1'b1);
        collect();
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (OutValid) extra++;
        end
        check("no_stale_out_valid", 32'(extra), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vreduce_acc.md
Name: vreduce_acc

Overview:
- Horizontal reduction unit for the SIMD FIR datapath. Consumes one packed 256-bit vector of 16 x 16-bit lanes, as produced by the lane-wise vector adder, and returns a single scalar: the sum of all lanes.
- The vector adder works lane-parallel and vertically. This block performs the horizontal step sequentially, summing LANES_PER_CYCLE lanes per clock, to produce the final FIR tap sum.
- Uses a valid/ready handshake on both sides.

Parameters:
- LANES, 16, number of lanes in the input vector.
- LANE_W, 16, width of each lane in bits.
- LANES_PER_CYCLE, 4, lanes added per ACCUM cycle. Must divide LANES.
- ACC_W, 20, accumulator and result width. Equals LANE_W + log2(LANES).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- InValid  input  1  Vector and Signed are valid this cycle.
- InReady  output  1  block can accept a vector.
- Vector  input  LANES*LANE_W  packed lanes; lane i = Vector[i*LANE_W +: LANE_W].
- Signed  input  1  1 = lanes are two's complement, sign-extend; 0 = zero-extend.
- OutValid  output  1  Result is valid.
- OutReady  input  1  consumer accepts Result.
- Result  output  ACC_W  sum of all lanes.
- Sat  output  1  saturation occurred (see Optional Feature).

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; accumulator = 0; lane index = 0; captured vector = 0.
  - InReady = 0 while in reset, 1 on the first cycle after release.
  - OutValid = 0, Result = 0, Sat = 0.
- IDLE:
  - InReady = 1, OutValid = 0.
  - On InValid & InReady: capture Vector and Signed into internal registers, clear the accumulator, set the lane index to 0, go to ACCUM.
- ACCUM:
  - InReady = 0.
  - Each cycle: accumulator += sum of lanes [idx .. idx+LANES_PER_CYCLE-1], each extended to ACC_W according to the captured Signed. Then idx += LANES_PER_CYCLE.
  - When the final group has been added (idx reaches LANES - LANES_PER_CYCLE), go to DONE.
  - With the defaults this takes 4 ACCUM cycles.
- DONE:
  - OutValid = 1. Result = accumulator, held stable until the handshake completes.
  - On OutValid & OutReady: go to IDLE and drop OutValid the next cycle.
  - OutReady may be held low indefinitely. Result and Sat must not change while waiting.
- Latency: the input handshake at cycle T gives OutValid at T + LANES/LANES_PER_CYCLE + 1 (cycle T+5 with the defaults).
- Throughput: one vector per (LANES/LANES_PER_CYCLE + 2) cycles minimum. There is no overlap of input and output.
- Arithmetic:
  - ACC_W is wide enough that the full sum never overflows.
  - Unsigned maximum: 16 x 0xFFFF = 0xFFFF0.
  - Signed minimum: 16 x 0x8000 = -524288 = 0x80000.
  - Wrap-around is therefore impossible without the optional feature.
- Boundary conditions:
  - InValid outside IDLE is ignored, because InReady = 0. The vector is not captured.
  - Vector and Signed may change after capture without affecting the result in progress.
  - Reset asserted mid-ACCUM or mid-DONE aborts the operation immediately. No stale OutValid follows after reset is released.
  - OutReady high outside DONE has no effect.

Optional Feature:
- Macro: VREDUCE_SAT_EN.
- When defined: in DONE, Result is clamped to the LANE_W range, sign-extended to ACC_W.
  - Signed = 1: clamp to [-32768, 32767].
  - Signed = 0: clamp to [0, 65535].
  - Sat = 1 when clamping changed the value.
  - Clamping is registered on entry to DONE. Latency is unchanged.
- When not defined: Result is the full ACC_W sum and Sat is tied to 0.

Test Plan:
- Reset behaviour: pulse rst_n low with random inputs -> OutValid = 0, Result = 0, Sat = 0; InReady = 0 during reset and 1 on the first cycle after release.
- Unsigned sum: all lanes 0x0001, Signed = 0, OutReady = 1 -> Result = 0x00010, OutValid at handshake + 5 cycles, one-cycle pulse.
- Signed minimum: all lanes 0x8000, Signed = 1 -> Result = 0x80000 (-524288), Sat = 0.
  - With VREDUCE_SAT_EN: Result = 0xF8000 (-32768), Sat = 1.
- Unsigned maximum: all lanes 0xFFFF, Signed = 0 -> Result = 0xFFFF0.
  - With VREDUCE_SAT_EN: Result = 0x0FFFF, Sat = 1.
- Backpressure and ignored input: lanes i = i (0..15), Signed = 0, OutReady held low 10 cycles -> Result = 120 held stable, InReady = 0. A second InValid during this time is not captured. After the OutReady handshake, the next vector is accepted.
- Reset mid-operation: assert rst_n low during the 2nd ACCUM cycle, release, then send all lanes 0x0002 -> only one OutValid, with Result = 0x00020.
